// File: rtl/io_pkg.sv
// Shared address-map constants for the memory-mapped I/O window at 0xFF0-0xFFF.
// No logic; the window decode helper is used by the responder.
package io_pkg;
  localparam logic [11:0] IO_BASE     = 12'hFF0;
  localparam logic [3:0]  IO_SW_LIVE  = 4'h0;
  localparam logic [3:0]  IO_SW_LATCH = 4'h1;
  localparam logic [3:0]  IO_STATUS   = 4'h2;
  localparam logic [3:0]  IO_DISP     = 4'h3;
  localparam logic [3:0]  IO_SEL      = 4'h4;

  localparam int IO_ST_NEW = 0;
  localparam int IO_ST_OVR = 1;

  function automatic logic io_hit(input logic [11:0] a);
    return a[11:4] == IO_BASE[11:4];
  endfunction
endpackage

// File: rtl/io_debounce.sv
// Button debouncer: level follows the input after DB_LIMIT consecutive differing cycles.
// Latency DB_LIMIT cycles to level; rise is a registered one-cycle pulse alongside the level change.
module io_debounce #(
  parameter logic [15:0] DB_LIMIT = 16'd50000,
  parameter int          DB_W     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam logic [DB_W-1:0] LIM_M1 = DB_W'(DB_LIMIT - 16'd1);

  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (din != level_q) begin
      if (cnt_q == LIM_M1) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder for 0xFF0-0xFFF: switches, button status, display registers.
// Read latency 1, no stalls. Define IO_DEBOUNCE_EN to insert the button debouncer.
module io_responder
  import io_pkg::*;
#(
  parameter logic [15:0] DB_LIMIT = 16'd50000,
  parameter int          DB_W     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  input  logic        wren,
  input  logic        rden,
  output logic        hit,
  output logic [15:0] rdata,
  output logic        rvalid,
  input  logic [15:0] sw,
  input  logic        btn,
  output logic [15:0] disp_val,
  output logic [2:0]  disp_sel,
  output logic        flag
);
  logic [15:0] sw_s1_q, sw_s2_q;
  logic        btn_s1_q, btn_s2_q;
  logic        press;

  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [15:0] latch_q, latch_d;
  logic        new_q, new_d;
  logic        ovr_q, ovr_d;
  logic [15:0] disp_q, disp_d;
  logic [2:0]  sel_q, sel_d;

  logic       wr, rd, clr;
  logic [3:0] off;

  assign hit = io_hit(addr);
  assign off = addr[3:0];
  assign wr  = wren && hit;
  assign rd  = rden && hit && !wren;
  assign clr = rd && (off == IO_SW_LATCH);

`ifdef IO_DEBOUNCE_EN
  logic db_level;

  io_debounce #(.DB_LIMIT(DB_LIMIT), .DB_W(DB_W)) u_debounce (
    .clock (clock),
    .reset (reset),
    .din   (btn_s2_q),
    .level (db_level),
    .rise  (press)
  );
`else
  logic btn_prev_q;

  always_ff @(posedge clock) begin
    if (!reset) btn_prev_q <= 1'b0;
    else        btn_prev_q <= btn_s2_q;
  end

  assign press = btn_s2_q & ~btn_prev_q;
`endif

  always_comb begin
    rvalid_d = rd;
    rdata_d  = rdata_q;
    if (rd) begin
      case (off)
        IO_SW_LIVE:  rdata_d = sw_s2_q;
        IO_SW_LATCH: rdata_d = latch_q;
        IO_STATUS:   rdata_d = {14'd0, ovr_q, new_q};
        IO_DISP:     rdata_d = disp_q;
        IO_SEL:      rdata_d = {13'd0, sel_q};
        default:     rdata_d = 16'd0;
      endcase
    end

    disp_d = (wr && off == IO_DISP) ? wdata : disp_q;
    sel_d  = (wr && off == IO_SEL) ? wdata[2:0] : sel_q;

    // A latch read clears status, but a press in the same cycle re-arms NEW without OVR.
    new_d   = clr ? 1'b0 : new_q;
    ovr_d   = clr ? 1'b0 : ovr_q;
    latch_d = latch_q;
    if (press) begin
      latch_d = sw_s2_q;
      new_d   = 1'b1;
      if (new_q && !clr) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      latch_q  <= '0;
      new_q    <= 1'b0;
      ovr_q    <= 1'b0;
      disp_q   <= '0;
      sel_q    <= '0;
    end else begin
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn;
      btn_s2_q <= btn_s1_q;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      latch_q  <= latch_d;
      new_q    <= new_d;
      ovr_q    <= ovr_d;
      disp_q   <= disp_d;
      sel_q    <= sel_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign disp_val = disp_q;
  assign disp_sel = sel_q;
  assign flag     = new_q;
endmodule

// File: doc/io_responder.md
# io_responder

Memory-mapped I/O responder on the processor's data-memory bus, the answering end of the accesses the processor initiates. It decodes the top 16 words of the 12-bit address space (0xFF0–0xFFF) and serves them with synchronous-RAM read latency. It returns synchronized and latched switch values and a button-event status register to the processor. It also holds the display value and digit-select registers that drive the seven-segment output block.

## Interface
Parameters:
- DB_LIMIT, 16'd50000: consecutive stable cycles required before the debounced button level changes.
- DB_W, 16: debounce counter width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  12  word address from processor.
- wdata  in  16  write data.
- wren  in  1  write strobe.
- rden  in  1  read strobe.
- hit  out  1  combinational: addr in 0xFF0–0xFFF; the top level uses it to steer read muxing away from RAM.
- rdata  out  16  registered read data.
- rvalid  out  1  one-cycle pulse with rdata.
- sw  in  16  asynchronous switch inputs.
- btn  in  1  asynchronous "enter" push-button, active-high.
- disp_val  out  16  display value register.
- disp_sel  out  3  display mode/select register.
- flag  out  1  mirror of STATUS bit0.

## Operation
Register map (word offsets within the window):
- 0xFF0 SW_LIVE (RO): 2-flop-synchronized sw.
- 0xFF1 SW_LATCH (RO): SW_LIVE captured on each button press event. A read clears STATUS.
- 0xFF2 STATUS (RO): bit0 = NEW (press pending), bit1 = OVR (press while NEW already set); bits 15:2 = 0.
- 0xFF3 DISP (RW): disp_val.
- 0xFF4 SEL (RW): bits 2:0 = disp_sel; upper read bits = 0.
- 0xFF5–0xFFF: reads return 0; writes ignored.

Access rules:
- Write when wren && hit. Writes to RO offsets are ignored.
- Read when rden && hit && !wren. If wren and rden are asserted together, the write wins and there is no read and no rvalid.

Button path:
- btn passes through a 2-flop synchronizer, then the debouncer.
- The debouncer's level changes after the synchronized input differs from the level for DB_LIMIT consecutive cycles. The counter clears on any agreement.
- Press event = rising edge of the debounced level, a one-cycle pulse.

Press event handling:
- SW_LATCH ← SW_LIVE (same-cycle value).
- NEW ← 1.
- OVR ← 1 if NEW was already 1 and is not being cleared in that same cycle.

Simultaneous events:
- Event and SW_LATCH read in the same cycle: the read returns the old latch. The event wins, so NEW = 1 and OVR is left cleared.
- Release events have no effect.

## Timing
- Read latency 1: request on cycle N, so rdata and rvalid are valid on cycle N+1. rvalid is high for exactly one cycle. rdata holds its last value otherwise.
- A write updates disp_val/disp_sel on the edge of the request cycle, so the new value is visible in N+1.
- Back-to-back accesses run every cycle with no stall.
- btn edge to NEW visible: 2 (sync) + DB_LIMIT (debounce) + 1 (flag register) cycles.
- Reset (reset==0 at an edge), applied at any time including mid-debounce or mid-read:
  - rdata = 0, rvalid = 0, disp_val = 0, disp_sel = 0, flag = 0.
  - NEW = OVR = 0, SW_LATCH = 0.
  - Synchronizer flops, debounced level and counter = 0.
  - A read pending across reset produces no rvalid.

## Configuration
- IO_DEBOUNCE_EN defined: debouncer instantiated as above.
- Undefined: debounced level = synchronized btn directly; DB_LIMIT is unused; btn-to-NEW latency is 3 cycles. All else is identical.

## Structure
- Shared package io_pkg:
  - IO_BASE = 12'hFF0.
  - Offset constants IO_SW_LIVE, IO_SW_LATCH, IO_STATUS, IO_DISP, IO_SEL.
  - STATUS bit indices.
- One sub-module, io_debounce (synchronizer excluded), parameterized by DB_LIMIT/DB_W. Outputs: level and rise pulse.

## Test plan
Bench uses DB_LIMIT=4.
- Reset: after reset, all outputs 0. Read 0xFF2 → rdata 16'h0000 on the next cycle with rvalid high for 1 cycle.
- Write/read-back: write 0xFF3=16'hBEEF and 0xFF4=16'hFFFF → disp_val=BEEF, disp_sel=3'b111. Read 0xFF4 → 16'h0007. Read 0xFF9 → 0. Write to 0xFF0 has no effect.
- Press: sw=16'h1234, btn high for 20 cycles → NEW set exactly 7 cycles after the btn edge (3 without the macro). Read 0xFF1 → 1234, then STATUS reads 0.
- Bounce: btn toggles every 2 cycles for 20 cycles, then goes low → no event and STATUS stays 0 (with IO_DEBOUNCE_EN).
- Overrun/collision: two presses without a read → STATUS=16'h0003. A press event coinciding with the SW_LATCH read → old latch returned, then STATUS=16'h0001.
- Priority/reset: wren and rden together at 0xFF3 → write occurs, no rvalid. Reset asserted the cycle after a read request → no rvalid, all registers 0.
